// File: rtl/axis_fifo_fwft.sv
// Single-clock first-word-fall-through AXI-Stream FIFO with a RAM plus one-entry head register.
// Define AXIS_FIFO_PKT_MODE_EN to hold output until a whole packet (TLAST) is buffered.
module axis_fifo_fwft #(
    parameter int    DSIZE    = 32,
    parameter int    ASIZE    = 9,
    parameter int    AF_LEVEL = (1 << ASIZE) - 2,
    parameter int    AE_LEVEL = 2,
    parameter string RAM_TYPE = "block"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] din_TDATA,
    input  logic             din_TLAST,
    input  logic             din_TVALID,
    output logic             din_TREADY,
    output logic [DSIZE-1:0] dout_TDATA,
    output logic             dout_TLAST,
    output logic             dout_TVALID,
    input  logic             dout_TREADY,
    output logic [ASIZE:0]   count,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] C_ONE   = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] C_DEPTH = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] C_AF    = (ASIZE + 1)'(AF_LEVEL);
    localparam logic [ASIZE:0] C_AE    = (ASIZE + 1)'(AE_LEVEL);

    if (!(RAM_TYPE == "auto" || RAM_TYPE == "block" || RAM_TYPE == "distributed")) begin : g_bad_ram_type
        $error("axis_fifo_fwft: RAM_TYPE must be auto, block or distributed");
    end

    (* ram_style = RAM_TYPE *)
    logic [DSIZE:0]   r_mem [DEPTH];
    logic [ASIZE:0]   r_wr_ptr;
    logic [ASIZE:0]   r_wr_ptr_d;
    logic [ASIZE:0]   r_rd_ptr;
    logic [ASIZE:0]   r_count;
    logic             r_head_valid;
    logic [DSIZE-1:0] r_out_data;
    logic             r_out_last;

    logic w_wr_accept;
    logic w_rd_accept;
    logic w_ram_has_data;
    logic w_refill;

    assign din_TREADY  = (r_count < C_DEPTH) & ~rst;
    assign w_wr_accept = din_TVALID & din_TREADY;
    assign w_rd_accept = dout_TVALID & dout_TREADY;

    // The head only sees RAM words one cycle after they are written, so a RAM
    // read never targets the address being written on the same edge.
    assign w_ram_has_data = (r_wr_ptr_d != r_rd_ptr);
    assign w_refill       = w_ram_has_data & (~r_head_valid | w_rd_accept);

    // NOTE: the storage array has no reset so it can map onto RAM primitives;
    // pointers and the head register carry all reset state.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[ASIZE-1:0]] <= {din_TLAST, din_TDATA};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_wr_ptr_d <= '0;
        end else begin
            r_wr_ptr_d <= r_wr_ptr;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_head_valid <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else if (w_refill) begin
            {r_out_last, r_out_data} <= r_mem[r_rd_ptr[ASIZE-1:0]];
            r_rd_ptr                 <= r_rd_ptr + C_ONE;
            r_head_valid             <= 1'b1;
        end else if (w_rd_accept) begin
            r_head_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count        = r_count;
    assign almost_full  = (r_count >= C_AF);
    assign almost_empty = (r_count <= C_AE);
    assign dout_TDATA   = r_out_data;
    assign dout_TLAST   = r_out_last;

`ifdef AXIS_FIFO_PKT_MODE_EN
    logic [ASIZE:0] r_pkt_cnt;
    logic           r_flush;
    logic           w_pkt_wr;
    logic           w_pkt_rd;

    assign w_pkt_wr = w_wr_accept & din_TLAST;
    assign w_pkt_rd = w_rd_accept & r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= '0;
            r_flush   <= 1'b0;
        end else begin
            case ({w_pkt_wr, w_pkt_rd})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + C_ONE;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - C_ONE;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
            // A full FIFO with no complete packet would deadlock; stream it out
            // until the oversized packet's TLAST leaves.
            if (w_pkt_rd) begin
                r_flush <= 1'b0;
            end else if (r_count == C_DEPTH && r_pkt_cnt == '0) begin
                r_flush <= 1'b1;
            end
        end
    end

    assign dout_TVALID = r_head_valid & ((r_pkt_cnt != '0) | r_flush);
`else
    assign dout_TVALID = r_head_valid;
`endif

endmodule

// File: tb/tb_axis_fifo_fwft.sv
// Self-checking bench for axis_fifo_fwft (DEPTH=16); a queue scoreboard checks every word read.
module tb_axis_fifo_fwft;

    localparam int DSIZE = 32;
    localparam int ASIZE = 4;
    localparam int DEPTH = 1 << ASIZE;

    logic             clk = 1'b0;
    logic             rst;
    logic [DSIZE-1:0] din_TDATA;
    logic             din_TLAST;
    logic             din_TVALID;
    logic             din_TREADY;
    logic [DSIZE-1:0] dout_TDATA;
    logic             dout_TLAST;
    logic             dout_TVALID;
    logic             dout_TREADY;
    logic [ASIZE:0]   count;
    logic             almost_full;
    logic             almost_empty;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DSIZE:0] sb_q[$];

    axis_fifo_fwft #(
        .DSIZE    (DSIZE),
        .ASIZE    (ASIZE),
        .AF_LEVEL (14),
        .AE_LEVEL (2),
        .RAM_TYPE ("block")
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .din_TDATA    (din_TDATA),
        .din_TLAST    (din_TLAST),
        .din_TVALID   (din_TVALID),
        .din_TREADY   (din_TREADY),
        .dout_TDATA   (dout_TDATA),
        .dout_TLAST   (dout_TLAST),
        .dout_TVALID  (dout_TVALID),
        .dout_TREADY  (dout_TREADY),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Handshakes are stable mid-cycle, so the negedge sees what the next posedge will accept.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (dout_TVALID && dout_TREADY) begin
                if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
                else check("sb_data", {dout_TLAST, dout_TDATA}, sb_q.pop_front());
            end
            if (din_TVALID && din_TREADY) sb_q.push_back({din_TLAST, din_TDATA});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        dout_TREADY = 1'b1;
        for (int n = 0; n < 64 && count != 0; n++) step();
        check(tag, count, 0);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
        dout_TREADY = 1'b0;
    endtask

    initial begin
        int  wdat;
        int  n_rd;
        int  n_acc;
        bit  acc;
        bit  rd;
        bit  unstable;
        bit  saw_full;
        bit  early;
        logic [ASIZE:0] cnt_ref;

        rst         = 1'b1;
        din_TDATA   = '0;
        din_TLAST   = 1'b0;
        din_TVALID  = 1'b0;
        dout_TREADY = 1'b0;

        step();
        check("rst_count", count, 0);
        check("rst_dout_valid", dout_TVALID, 0);
        check("rst_dout_data", dout_TDATA, 0);
        check("rst_dout_last", dout_TLAST, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_almost_full", almost_full, 0);
        check("rst_din_tready", din_TREADY, 0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_din_tready", din_TREADY, 1);

`ifdef AXIS_FIFO_PKT_MODE_EN
        // 5-word packet: nothing visible until the TLAST word is written.
        dout_TREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din_TDATA  = 300 + i;
            din_TLAST  = (i == 4);
            din_TVALID = 1'b1;
            step();
            if (i < 4) check("pkt_hold_valid", dout_TVALID, 0);
        end
        din_TVALID = 1'b0;
        din_TLAST  = 1'b0;
        check("pkt_release_valid", dout_TVALID, 1);
        drain("pkt5_drain");

        // 20-word packet: must flush at full and stream without deadlock.
        dout_TREADY = 1'b1;
        n_acc    = 0;
        saw_full = 1'b0;
        early    = 1'b0;
        for (int c = 0; c < 200; c++) begin
            din_TVALID = (n_acc < 20);
            din_TDATA  = 400 + n_acc;
            din_TLAST  = (n_acc == 19);
            acc = din_TVALID && din_TREADY;
            step();
            if (acc) n_acc++;
            if (count == DEPTH) saw_full = 1'b1;
            if (dout_TVALID && n_acc < 20) early = 1'b1;
            if (n_acc == 20 && count == 0) break;
        end
        din_TVALID = 1'b0;
        din_TLAST  = 1'b0;
        check("pkt20_accepted", n_acc, 20);
        check("pkt20_reached_full", saw_full, 1);
        check("pkt20_flush_before_tlast", early, 1);
        check("pkt20_count_end", count, 0);
        dout_TREADY = 1'b0;
`else
        // Single write into an empty FIFO: visible two edges later.
        din_TDATA  = 32'hA5A5_0001;
        din_TVALID = 1'b1;
        step();
        din_TVALID = 1'b0;
        check("lat_k0_valid", dout_TVALID, 0);
        check("lat_k0_count", count, 1);
        step();
        check("lat_k1_valid", dout_TVALID, 0);
        step();
        check("lat_k2_valid", dout_TVALID, 1);
        check("lat_k2_data", dout_TDATA, 32'hA5A5_0001);
        check("lat_k2_count", count, 1);
        check("lat_k2_almost_empty", almost_empty, 1);
        dout_TREADY = 1'b1;
        step();
        dout_TREADY = 1'b0;
        check("single_read_count", count, 0);
        check("single_read_valid", dout_TVALID, 0);

        // Fill to capacity with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) begin
            din_TDATA  = i;
            din_TLAST  = (i == DEPTH - 1);
            din_TVALID = 1'b1;
            step();
            check("fill_count", count, i + 1);
            check("fill_almost_full", almost_full, (i + 1) >= 14);
            check("fill_almost_empty", almost_empty, (i + 1) <= 2);
            check("fill_din_tready", din_TREADY, (i + 1) < DEPTH);
        end
        din_TDATA = 32'h0000_0BAD;
        din_TLAST = 1'b0;
        step();
        check("overflow_count", count, DEPTH);
        check("overflow_din_tready", din_TREADY, 0);
        check("full_head_data", dout_TDATA, 0);

        // Full with read and write requested together: only the read happens.
        dout_TREADY = 1'b1;
        step();
        din_TVALID = 1'b0;
        check("full_rw_count", count, DEPTH - 1);
        check("full_rw_din_tready", din_TREADY, 1);
        drain("fill_drain");

        // Continuous streaming, both sides always ready.
        wdat        = 1000;
        din_TDATA   = wdat;
        din_TLAST   = 1'b0;
        din_TVALID  = 1'b1;
        dout_TREADY = 1'b1;
        n_rd        = 0;
        unstable    = 1'b0;
        cnt_ref     = '0;
        for (int c = 0; c < 120; c++) begin
            acc = din_TVALID && din_TREADY;
            rd  = dout_TVALID && dout_TREADY;
            step();
            if (acc) begin
                wdat++;
                din_TDATA = wdat;
                din_TLAST = (wdat % 7 == 0);
            end
            if (c == 9) cnt_ref = count;
            if (c >= 10 && c < 110) begin
                if (rd) n_rd++;
                if (count != cnt_ref) unstable = 1'b1;
            end
        end
        din_TVALID = 1'b0;
        check("stream_rate", n_rd, 100);
        check("stream_count_stable", unstable, 0);
        check("stream_count_level", cnt_ref, 3);
        drain("stream_drain");

        // Reset in the middle of a stream discards everything.
        for (int i = 0; i < 9; i++) begin
            din_TDATA  = 200 + i;
            din_TLAST  = 1'b0;
            din_TVALID = 1'b1;
            step();
        end
        check("pre_rst_count", count, 9);
        rst = 1'b1;
        step();
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", dout_TVALID, 0);
        check("mid_rst_data", dout_TDATA, 0);
        check("mid_rst_din_tready", din_TREADY, 0);
        step();
        check("mid_rst_din_tready_hold", din_TREADY, 0);
        din_TVALID = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_release_tready", din_TREADY, 1);
        repeat (3) step();
        check("post_rst_empty_valid", dout_TVALID, 0);
        check("post_rst_empty_count", count, 0);
`endif

        check("final_sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
